// File: rtl/noc_pkg.sv
// Shared flit layout and router-wide constants for the NoC output port.
package noc_pkg;
    localparam int FLIT_W      = 23;
    localparam int PAYLOAD_MSB = 22;
    localparam int PAYLOAD_LSB = 7;
    localparam int ADDR_MSB    = 6;
    localparam int ADDR_LSB    = 3;
    localparam int TGT_MSB     = 2;
    localparam int TGT_LSB     = 0;
    localparam int TGT_W       = TGT_MSB - TGT_LSB + 1;
    localparam int BUF_DEPTH   = 9;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic {
        PORT_IDLE = 1'b0,
        PORT_SEND = 1'b1
    } port_state_t;
endpackage

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at a rotating pointer that
// advances past the winner; no grant while en_i is low.
module noc_rr_arbiter #(
    parameter int N = 5,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic             en_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] gnt_idx_o
);
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     grant_d;
    logic [PTR_W-1:0] idx_d;
    logic             found;
    int               j;

    always_comb begin
        grant_d = '0;
        idx_d   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_q) + k) % N;
            if (en_i && !found && req_i[j]) begin
                found      = 1'b1;
                grant_d[j] = 1'b1;
                idx_d      = PTR_W'(j);
            end
        end
        if (int'(idx_d) == N - 1) ptr_d = '0;
        else                      ptr_d = idx_d + PTR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        ptr_q <= '0;
        else if (found) ptr_q <= ptr_d;
    end

    assign grant_o   = grant_d;
    assign gnt_idx_o = idx_d;
endmodule

// File: rtl/noc_output_port.sv
// Router output port: matches head flits to PORT_ID, arbitrates round-robin,
// pops the winner and drives a registered, credit-guarded link.
// Optional stall counter enabled by macro NOC_OPORT_STALL_CNT_EN.
module noc_output_port
    import noc_pkg::*;
#(
    parameter int N_IN    = 5,
    parameter int PORT_ID = 0,
    parameter int CREDITS = BUF_DEPTH,
    parameter int FLIT_W  = noc_pkg::FLIT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IN*FLIT_W-1:0] in_flit,
    input  logic [N_IN-1:0]        in_nempty,
    output logic [N_IN-1:0]        in_pop,
    input  logic                   credit_in,
    output logic                   out_valid,
    output logic [FLIT_W-1:0]      out_flit,
    output logic [3:0]             credits,
    output logic [15:0]            stall_cnt
);
    localparam int         PTR_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    logic [N_IN-1:0]   req;
    logic [N_IN-1:0]   grant;
    logic [PTR_W-1:0]  gnt_idx;
    logic              send;
    logic [FLIT_W-1:0] gnt_flit;
    logic [3:0]        credits_q, credits_d;
    logic              credit_ovf;
    port_state_t       state_q;
    logic [FLIT_W-1:0] flit_q;

    always_comb begin
        for (int i = 0; i < N_IN; i++)
            req[i] = in_nempty[i] &&
                     (in_flit[i*FLIT_W + TGT_LSB +: TGT_W] == TGT_W'(PORT_ID));
    end

    noc_rr_arbiter #(.N(N_IN)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .en_i      (credits_q != 4'd0),
        .grant_o   (grant),
        .gnt_idx_o (gnt_idx)
    );

    // Popping during reset would corrupt buffers that are being reset alongside us.
    assign in_pop   = rst ? '0 : grant;
    assign send     = |in_pop;
    assign gnt_flit = in_flit[int'(gnt_idx)*FLIT_W +: FLIT_W];

    always_comb begin
        credits_d  = credits_q;
        credit_ovf = 1'b0;
        unique case ({send, credit_in})
            2'b10: credits_d = credits_q - 4'd1;
            2'b01: begin
                if (credits_q == CRED_MAX) credit_ovf = 1'b1;
                else                       credits_d  = credits_q + 4'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PORT_IDLE;
            flit_q    <= '0;
            credits_q <= CRED_MAX;
        end else begin
            credits_q <= credits_d;
            unique case (state_q)
                PORT_IDLE: if (send) state_q <= PORT_SEND;
                PORT_SEND: if (!send) state_q <= PORT_IDLE;
                default:   state_q <= PORT_IDLE;
            endcase
            if (send) flit_q <= gnt_flit;
        end
    end

    assign out_valid = (state_q == PORT_SEND);
    assign out_flit  = flit_q;
    assign credits   = credits_q;

`ifdef NOC_OPORT_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else if ((|req) && (credits_q == 4'd0) && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

`ifndef SYNTHESIS
    // Returning a credit while already full means downstream lost count.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!credit_ovf)
            else $warning("noc_output_port: credit_in while credits already at maximum");
        end
    end
`endif
endmodule

// File: tb/tb_noc_output_port.sv
// Scoreboard bench for noc_output_port (N_IN=5, PORT_ID=2, CREDITS=9).
module tb_noc_output_port;
    localparam int N_IN = 5;
    localparam int FW   = 23;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N_IN*FW-1:0] in_flit;
    logic [N_IN-1:0]   in_nempty = '0;
    logic [N_IN-1:0]   in_pop;
    logic              credit_in = 1'b0;
    logic              out_valid;
    logic [FW-1:0]     out_flit;
    logic [3:0]        credits;
    logic [15:0]       stall_cnt;

    logic [FW-1:0] heads     [N_IN];
    logic [FW-1:0] nxt_heads [N_IN];
    logic [FW-1:0] exp_q [$];
    int tests = 0;
    int fails = 0;

    noc_output_port #(.N_IN(N_IN), .PORT_ID(2), .CREDITS(9), .FLIT_W(FW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_nempty (in_nempty),
        .in_pop    (in_pop),
        .credit_in (credit_in),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .credits   (credits),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N_IN; i++) in_flit[i*FW +: FW] = heads[i];
    end

    function automatic logic [FW-1:0] mk(input logic [15:0] p, input logic [3:0] a, input logic [2:0] t);
        return {p, a, t};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got flit %0h, expected no output (t=%0t)", out_flit, $time);
                end else begin
                    chk("out_flit", 32'(out_flit), 32'(exp_q.pop_front()));
                end
            end
        end
    endtask

    // One cycle: apply inputs after the falling edge, check the combinational pop and current state.
    task automatic step(input logic [N_IN-1:0] ne, input logic ci, input logic [N_IN-1:0] ep,
                        input logic [3:0] ec, input logic eov, input string nm);
        @(negedge clk);
        for (int i = 0; i < N_IN; i++) heads[i] = nxt_heads[i];
        in_nempty = ne;
        credit_in = ci;
        #1;
        chk({nm, "_pop"}, 32'(in_pop), 32'(ep));
        chk({nm, "_cred"}, 32'(credits), 32'(ec));
        chk({nm, "_ov"}, 32'(out_valid), 32'(eov));
        for (int i = 0; i < N_IN; i++) if (ep[i]) exp_q.push_back(heads[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_nempty = '0;
        credit_in = 1'b0;
        #1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gs[6];
        gs = '{0, 2, 4, 0, 2, 4};
        for (int i = 0; i < N_IN; i++) begin
            heads[i] = '0;
            nxt_heads[i] = '0;
        end
        fork monitor(); join_none

        // Reset state, with a matching request present
        @(negedge clk);
        heads[1] = mk(16'hFFFF, 4'h1, 3'd2);
        in_nempty = 5'b00010;
        #1;
        chk("rst_pop", 32'(in_pop), 32'h0);
        chk("rst_ov", 32'(out_valid), 32'h0);
        chk("rst_flit", 32'(out_flit), 32'h0);
        chk("rst_cred", 32'(credits), 32'd9);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        in_nempty = '0;

        // Single flit from input 1
        nxt_heads[1] = 23'h7FFF8A;
        step(5'b00010, 1'b0, 5'b00010, 4'd9, 1'b0, "t1_grant");
        step(5'b00000, 1'b0, 5'b00000, 4'd8, 1'b1, "t1_out");
        step(5'b00000, 1'b0, 5'b00000, 4'd8, 1'b0, "t1_idle");

        // Round-robin over inputs 0,2,4 with heads refreshed every cycle
        do_reset();
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N_IN; i++) nxt_heads[i] = mk(16'h100 + 16'(k*8 + i), 4'(i), 3'd2);
            step(5'b10101, 1'b0, 5'(1) << gs[k], 4'(9 - k), k > 0, "t2_rr");
        end
        step(5'b00000, 1'b0, 5'b00000, 4'd3, 1'b1, "t2_end");

        // Drain to zero credits, then a single credit gives exactly one send
        begin
            logic [N_IN-1:0] ep3 [9];
            logic [3:0]      ec3 [9];
            logic            ov3 [9];
            logic            ci3 [9];
            ep3 = '{5'b00001, 5'b00001, 5'b00001, 5'b0, 5'b0, 5'b0, 5'b00001, 5'b0, 5'b0};
            ec3 = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
            ov3 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            ci3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            for (int k = 0; k < 9; k++) begin
                nxt_heads[0] = mk(16'h300 + 16'(k), 4'h0, 3'd2);
                step((k == 8) ? 5'b00000 : 5'b00001, ci3[k], ep3[k], ec3[k], ov3[k], "t3_cred");
            end
        end

        // Simultaneous send and credit return, then saturation at full
        for (int k = 0; k < 5; k++) step(5'b00000, 1'b1, 5'b00000, 4'(k), 1'b0, "t4_fill");
        nxt_heads[0] = mk(16'h4444, 4'h4, 3'd2);
        step(5'b00001, 1'b1, 5'b00001, 4'd5, 1'b0, "t4_both");
        step(5'b00000, 1'b0, 5'b00000, 4'd5, 1'b1, "t4_after");
        for (int k = 0; k < 4; k++) step(5'b00000, 1'b1, 5'b00000, 4'(5 + k), 1'b0, "t4_refill");
        step(5'b00000, 1'b1, 5'b00000, 4'd9, 1'b0, "t4_full");
        step(5'b00000, 1'b0, 5'b00000, 4'd9, 1'b0, "t4_sat");

        // Non-matching target, and a matching head in an empty buffer
        nxt_heads[3] = mk(16'h0555, 4'h3, 3'd3);
        step(5'b01000, 1'b0, 5'b00000, 4'd9, 1'b0, "t5_tgt");
        step(5'b01000, 1'b0, 5'b00000, 4'd9, 1'b0, "t5_tgt2");
        for (int i = 0; i < N_IN; i++) nxt_heads[i] = mk(16'h0AAA, 4'(i), 3'd2);
        step(5'b00000, 1'b0, 5'b00000, 4'd9, 1'b0, "t5_empty");
        step(5'b00000, 1'b0, 5'b00000, 4'd9, 1'b0, "t5_empty2");

        // Asynchronous reset while a flit is on the link
        nxt_heads[1] = mk(16'hBEEF, 4'h6, 3'd2);
        step(5'b00010, 1'b0, 5'b00010, 4'd9, 1'b0, "t6_grant");
        @(posedge clk);
        #2;
        chk("t6_pre_ov", 32'(out_valid), 32'h1);
        chk("t6_pre_cred", 32'(credits), 32'd8);
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("t6_rst_ov", 32'(out_valid), 32'h0);
        chk("t6_rst_cred", 32'(credits), 32'd9);
        chk("t6_rst_pop", 32'(in_pop), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        in_nempty = '0;

        // Zero-credit stall with a pending request for 20 cycles
        for (int k = 0; k < 9; k++) begin
            nxt_heads[0] = mk(16'h700 + 16'(k), 4'h7, 3'd2);
            step(5'b00001, 1'b0, 5'b00001, 4'(9 - k), k > 0, "t7_send");
        end
        for (int k = 0; k < 20; k++) step(5'b00001, 1'b0, 5'b00000, 4'd0, k == 0, "t7_stall");
        step(5'b00000, 1'b0, 5'b00000, 4'd0, 1'b0, "t7_end");
`ifdef NOC_OPORT_STALL_CNT_EN
        chk("t7_stall_cnt", 32'(stall_cnt), 32'd20);
`else
        chk("t7_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        do_reset();
        #1;
        chk("t7_stall_rst", 32'(stall_cnt), 32'd0);
        chk("t7_cred_rst", 32'(credits), 32'd9);

        repeat (2) @(negedge clk);
        #1;
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
